// File: rtl/fpga_cfg_loader.sv
// Configuration-load controller: takes host words over a valid/ready stream, shifts them
// LSB-first into one column chain at a time, then pulses the set strobe on every column.
module fpga_cfg_loader #(
    parameter int unsigned NUM_COLS     = 2,
    parameter int unsigned BITS_PER_COL = 40,
    parameter int unsigned WORD_W       = 16
) (
    input  logic                cclk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                mode_soft,
    input  logic                abort,
    input  logic [WORD_W-1:0]   in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [NUM_COLS-1:0] shift_enable,
    output logic [NUM_COLS-1:0] shift_in_hard,
    output logic [NUM_COLS-1:0] shift_in_soft,
    output logic [NUM_COLS-1:0] set_hard,
    output logic [NUM_COLS-1:0] set_soft,
    output logic                busy,
    output logic                done
);

    localparam int unsigned LenMax = (WORD_W > BITS_PER_COL) ? WORD_W : BITS_PER_COL;
    localparam int unsigned LenW   = $clog2(LenMax + 1);
    localparam int unsigned FcW    = $clog2(NUM_COLS + 1);
    localparam int unsigned ColW   = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;

    localparam logic [LenW-1:0] WordLen = LenW'(WORD_W);
    localparam logic [LenW-1:0] ColLen  = LenW'(BITS_PER_COL);
    localparam logic [FcW-1:0]  AllCols = FcW'(NUM_COLS);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StCommit,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [WORD_W-1:0] data_buf_q, data_buf_d;
    logic [LenW-1:0]   cnt_q, cnt_d;
    logic [LenW-1:0]   fill_left_q, fill_left_d;
    logic [FcW-1:0]    fill_col_q, fill_col_d;
    logic [ColW-1:0]   shift_col_q, shift_col_d;
    logic              mode_q, mode_d;
    logic [LenW-1:0]   load_len;
    logic              accept;

    // Shifter can take a word when empty or on its last bit; abort blocks acceptance.
    assign in_ready = (state_q == StLoad) && !abort && (cnt_q <= LenW'(1))
                      && (fill_col_q < AllCols);
    assign accept   = in_valid && in_ready;
    // The last word of a column only carries the bits still owed to that column.
    assign load_len = (fill_left_q > WordLen) ? WordLen : fill_left_q;

    // Next-state: FSM sequencing, word fill bookkeeping and the serial shifter.
    always_comb begin
        state_d     = state_q;
        data_buf_d  = data_buf_q;
        cnt_d       = cnt_q;
        fill_left_d = fill_left_q;
        fill_col_d  = fill_col_q;
        shift_col_d = shift_col_q;
        mode_d      = mode_q;

        if (cnt_q != '0) begin
            data_buf_d = data_buf_q >> 1;
            cnt_d      = cnt_q - LenW'(1);
        end

        if (abort) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_d     = StLoad;
                        mode_d      = mode_soft;
                        fill_col_d  = '0;
                        fill_left_d = ColLen;
                    end
                end
                StLoad: begin
                    if (accept) begin
                        // Reload overrides the shift above, giving gapless words at cnt==1.
                        data_buf_d  = in_data;
                        cnt_d       = load_len;
                        shift_col_d = fill_col_q[ColW-1:0];
                        if (fill_left_q == load_len) begin
                            fill_col_d  = fill_col_q + FcW'(1);
                            fill_left_d = ColLen;
                        end else begin
                            fill_left_d = fill_left_q - load_len;
                        end
                    end else if ((fill_col_q == AllCols) && (cnt_q == '0)) begin
                        state_d = StCommit;
                    end
                end
                StCommit: state_d = StDone;
                StDone:   state_d = StIdle;
                default:  state_d = StIdle;
            endcase
        end
    end

    // Chain and commit outputs decode registered state only.
    always_comb begin
        shift_enable  = '0;
        shift_in_hard = '0;
        shift_in_soft = '0;
        set_hard      = '0;
        set_soft      = '0;
        if (cnt_q != '0) begin
            shift_enable[shift_col_q] = 1'b1;
            if (mode_q) begin
                shift_in_soft[shift_col_q] = data_buf_q[0];
            end else begin
                shift_in_hard[shift_col_q] = data_buf_q[0];
            end
        end
        if (state_q == StCommit) begin
            if (mode_q) begin
                set_soft = '1;
            end else begin
                set_hard = '1;
            end
        end
    end

    assign busy = (state_q == StLoad) || (state_q == StCommit);
    assign done = (state_q == StDone);

    // State registers with asynchronous active-low reset.
    always_ff @(posedge cclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            data_buf_q  <= '0;
            cnt_q       <= '0;
            fill_left_q <= '0;
            fill_col_q  <= '0;
            shift_col_q <= '0;
            mode_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_buf_q  <= data_buf_d;
            cnt_q       <= cnt_d;
            fill_left_q <= fill_left_d;
            fill_col_q  <= fill_col_d;
            shift_col_q <= shift_col_d;
            mode_q      <= mode_d;
        end
    end

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Bench for fpga_cfg_loader: random and patterned loads checked cycle by cycle against a
// queue-based model of the expected serial bit stream and control pulses.
module tb_fpga_cfg_loader;

    localparam int NUM_COLS     = 2;
    localparam int BITS_PER_COL = 40;
    localparam int WORD_W       = 16;
    localparam int MAX_CYC      = 1000;

    logic                cclk      = 1'b0;
    logic                rst_n     = 1'b1;
    logic                start     = 1'b0;
    logic                mode_soft = 1'b0;
    logic                abort     = 1'b0;
    logic [WORD_W-1:0]   in_data   = '0;
    logic                in_valid  = 1'b0;
    logic                in_ready;
    logic [NUM_COLS-1:0] shift_enable, shift_in_hard, shift_in_soft, set_hard, set_soft;
    logic                busy, done;

    int n_checks = 0;
    int n_fail   = 0;

    fpga_cfg_loader #(
        .NUM_COLS    (NUM_COLS),
        .BITS_PER_COL(BITS_PER_COL),
        .WORD_W      (WORD_W)
    ) u_dut (
        .cclk         (cclk),
        .rst_n        (rst_n),
        .start        (start),
        .mode_soft    (mode_soft),
        .abort        (abort),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .shift_enable (shift_enable),
        .shift_in_hard(shift_in_hard),
        .shift_in_soft(shift_in_soft),
        .set_hard     (set_hard),
        .set_soft     (set_soft),
        .busy         (busy),
        .done         (done)
    );

    always #5 cclk = ~cclk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: load phase plus a queue of bits still owed to the chains.
    typedef enum int {MIdle, MLoad, MCommit, MDone} mphase_e;
    mphase_e ph = MIdle;
    logic    m_mode = 1'b0;
    int      m_col = 0;
    int      m_left = 0;
    bit      pend_bit[$];
    int      pend_col[$];

    // Observed-side bookkeeping.
    bit mon_en    = 1'b0;
    bit contig    = 1'b0;
    int cyc_ctr   = 0;
    int first_sh  = -1;
    int last_sh   = -1;
    int ld_bits   = 0;
    int acc_words = 0;
    int obs_done  = 0;
    int col_bits[NUM_COLS];

    function automatic logic [WORD_W-1:0] pat_word(input int i);
        return 16'hA5A5 ^ 16'(i * 16'h1111);
    endfunction

    task automatic model_reset();
        ph = MIdle;
        pend_bit.delete();
        pend_col.delete();
    endtask

    // One cycle of checking at the falling edge, then advance the model to the next edge.
    task automatic step();
        logic [NUM_COLS-1:0] e_en, e_h, e_s, e_sh, e_ss;
        logic                e_busy, e_done, e_rdy;
        bit                  had_bits;
        int                  n;
        e_en = '0; e_h = '0; e_s = '0; e_sh = '0; e_ss = '0;
        cyc_ctr++;
        had_bits = pend_bit.size() > 0;
        if (had_bits) begin
            e_en[pend_col[0]] = 1'b1;
            if (m_mode) e_s[pend_col[0]] = pend_bit[0];
            else        e_h[pend_col[0]] = pend_bit[0];
        end
        e_rdy  = (ph == MLoad) && !abort && (pend_bit.size() <= 1) && (m_col < NUM_COLS);
        e_busy = (ph == MLoad) || (ph == MCommit);
        e_done = (ph == MDone);
        if (ph == MCommit) begin
            if (m_mode) e_ss = '1;
            else        e_sh = '1;
        end
        check_eq("shift", {shift_enable, shift_in_hard, shift_in_soft}, {e_en, e_h, e_s});
        check_eq("ctrl", {set_hard, set_soft, busy, done, in_ready},
                 {e_sh, e_ss, e_busy, e_done, e_rdy});

        // Observed stream statistics for per-column count and gap checks.
        if (shift_enable != '0) begin
            if (first_sh < 0) first_sh = cyc_ctr;
            last_sh = cyc_ctr;
            ld_bits++;
            for (int c = 0; c < NUM_COLS; c++) col_bits[c] += int'(shift_enable[c]);
        end
        if (done) begin
            obs_done++;
            for (int c = 0; c < NUM_COLS; c++) check_eq("col_bits", col_bits[c], BITS_PER_COL);
            if (contig) check_eq("gapless", last_sh - first_sh + 1, NUM_COLS * BITS_PER_COL);
        end

        if (had_bits) begin
            void'(pend_bit.pop_front());
            void'(pend_col.pop_front());
        end
        if (abort) begin
            model_reset();
        end else begin
            case (ph)
                MIdle: if (start) begin
                    ph = MLoad; m_mode = mode_soft; m_col = 0; m_left = BITS_PER_COL;
                end
                MLoad: begin
                    if (e_rdy && in_valid) begin
                        acc_words++;
                        n = (m_left < WORD_W) ? m_left : WORD_W;
                        for (int k = 0; k < n; k++) begin
                            pend_bit.push_back(in_data[k]);
                            pend_col.push_back(m_col);
                        end
                        m_left -= n;
                        if (m_left == 0) begin
                            m_col++;
                            m_left = BITS_PER_COL;
                        end
                    end else if (m_col == NUM_COLS && !had_bits) begin
                        ph = MCommit;
                    end
                end
                MCommit: ph = MDone;
                default: ph = MIdle;
            endcase
        end
    endtask

    always @(negedge cclk) if (mon_en) step();

    // vmode: 0 = valid always, 1 = toggle, 2 = random. abort_at/rst_at < 0 disables.
    task automatic run_load(input logic md, input int vmode, input bit fixed, input int abort_at,
                            input int rst_at, input bit spam, input bit cont);
        int  cyc;
        int  d0;
        bit  aborted;
        cyc = 0; aborted = 1'b0; d0 = obs_done;
        contig = cont; first_sh = -1; last_sh = -1; ld_bits = 0; acc_words = 0;
        for (int c = 0; c < NUM_COLS; c++) col_bits[c] = 0;
        start = 1'b1; mode_soft = md;
        @(posedge cclk); #1;
        start = 1'b0;
        while (ph != MIdle && cyc < MAX_CYC) begin
            if (rst_at >= 0 && ld_bits >= rst_at) begin
                rst_n = 1'b0; in_valid = 1'b0; #1;
                check_eq("rst_outs", {shift_enable, shift_in_hard, shift_in_soft, set_hard,
                                      set_soft, busy, done, in_ready}, '0);
                model_reset();
                @(posedge cclk); #1;
                rst_n = 1'b1;
                break;
            end
            case (vmode)
                0:       in_valid = 1'b1;
                1:       in_valid = cyc[0];
                default: in_valid = ($urandom_range(99) < 60);
            endcase
            in_data = fixed ? pat_word(acc_words) : WORD_W'($urandom);
            abort = (abort_at >= 0) && (ld_bits >= abort_at) && !aborted;
            if (abort) aborted = 1'b1;
            if (spam) begin
                start     = 1'($urandom_range(1));
                mode_soft = 1'($urandom_range(1));
            end
            @(posedge cclk); #1;
            cyc++;
        end
        abort = 1'b0; start = 1'b0; in_valid = 1'b0;
        check_eq("timeout", cyc >= MAX_CYC, 0);
        check_eq("done_cnt", obs_done - d0, (abort_at < 0 && rst_at < 0) ? 1 : 0);
        repeat (2) @(posedge cclk);
        #1;
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check_eq("reset_state", {shift_enable, shift_in_hard, shift_in_soft, set_hard, set_soft,
                                 busy, done, in_ready}, '0);
        #20;
        @(posedge cclk); #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(posedge cclk); #1;

        run_load(1'b0, 0, 1'b1, -1, -1, 1'b0, 1'b1);  // hard, continuous valid, gapless
        run_load(1'b1, 1, 1'b1, -1, -1, 1'b0, 1'b0);  // soft, valid toggling
        run_load(1'b0, 0, 1'b0, 50, -1, 1'b0, 1'b0);  // abort after 50 bits
        run_load(1'b1, 0, 1'b1, -1, -1, 1'b0, 1'b1);  // normal load after abort
        run_load(1'b0, 2, 1'b0, -1, -1, 1'b1, 1'b0);  // start/mode noise while busy
        run_load(1'b1, 2, 1'b0, -1, 30, 1'b0, 1'b0);  // reset mid-load
        for (int i = 0; i < 4; i++) begin
            run_load(1'($urandom_range(1)), 2, 1'b0, -1, -1, 1'($urandom_range(1)), 1'b0);
        end

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
